// File: rtl/nand_test_sequencer_if.sv
// Stimulus/check bus between the NAND test sequencer and the cell under test.
interface nand_test_sequencer_if #(
  parameter int unsigned ERR_W = 8
);
  logic             start;
  logic             abort;
  logic             loop;
  logic             y_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  // Sequencer side: receives control and the cell output, drives the cell and status.
  modport slave (
    input  start, abort, loop, y_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );

  // Controller/cell side: the mirror image of the sequencer view.
  modport master (
    output start, abort, loop, y_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/nand_test_sequencer.sv
// Walks a 2-input NAND through AB = 00,01,10,11, waits SETTLE_CYCLES per
// vector, samples Y and accumulates mismatches against ~(A & B).
module nand_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nand_test_sequencer_if.slave  bus
);

  localparam int unsigned        CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_W-1:0]   ERR_MAX  = '1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [1:0]       v_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_q;

  logic             mism_c;
  logic [ERR_W-1:0] err_d;
  logic [3:0]       fail_d;
  logic [1:0]       v_nxt_c;

  // Result of the current sample: saturating error count and sticky fail flag.
  always_comb begin
    mism_c  = (bus.y_in != ~(a_q & b_q));
    err_d   = err_q;
    fail_d  = fail_q;
    v_nxt_c = v_q + 2'd1;
    if (mism_c) begin
      fail_d[v_q] = 1'b1;
      if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
    end
  end

  // Sequencer FSM with registered stimulus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      v_q     <= 2'd0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fail_q  <= 4'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUN;
            v_q     <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            cnt_q   <= CNT_LOAD;
            err_q   <= '0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            // Abort wins over a coincident sample; results are left as-is.
            state_q <= IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            err_q  <= err_d;
            fail_q <= fail_d;
            if (v_q != 2'd3) begin
              v_q   <= v_nxt_c;
              a_q   <= v_nxt_c[1];
              b_q   <= v_nxt_c[0];
              cnt_q <= CNT_LOAD;
            end else begin
              done_q <= 1'b1;
              pass_q <= (err_d == '0);
              if (bus.loop) begin
                v_q   <= 2'd0;
                a_q   <= 1'b0;
                b_q   <= 1'b0;
                cnt_q <= CNT_LOAD;
              end else begin
                // Stimulus stays at 11 after a normal end of pass.
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule

// File: tb/tb_nand_test_sequencer.sv
// Directed bench: two sequencers (ERR_W=8 and ERR_W=2) driven in lockstep
// against a behavioural NAND that can be ideal, stuck-at-1 or stuck-at-0.
module tb_nand_test_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       loop;
  logic [1:0] y_mode;  // 0 ideal, 1 stuck-at-1, 2 stuck-at-0

  int unsigned n_total;
  int unsigned n_bad;

  nand_test_sequencer_if #(.ERR_W(8)) if8 ();
  nand_test_sequencer_if #(.ERR_W(2)) if2 ();

  assign if8.start = start;
  assign if8.abort = abort;
  assign if8.loop  = loop;
  assign if2.start = start;
  assign if2.abort = abort;
  assign if2.loop  = loop;

  assign if8.y_in = (y_mode == 2'd0) ? ~(if8.a_out & if8.b_out) : (y_mode == 2'd1);
  assign if2.y_in = (y_mode == 2'd0) ? ~(if2.a_out & if2.b_out) : (y_mode == 2'd1);

  nand_test_sequencer #(.SETTLE_CYCLES(2), .ERR_W(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  nand_test_sequencer #(.SETTLE_CYCLES(2), .ERR_W(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raise start so the next rising edge is E0, then drop it.
  task automatic pulse_start();
    start = 1'b1;
    adv(1);
    start = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic a, input logic b, input logic busy,
                            input logic done, input logic pass, input logic [7:0] err8,
                            input logic [1:0] err2, input logic [3:0] fv);
    chk_eq({tag, ".a"},    32'(if8.a_out),     32'(a));
    chk_eq({tag, ".b"},    32'(if8.b_out),     32'(b));
    chk_eq({tag, ".busy"}, 32'(if8.busy),      32'(busy));
    chk_eq({tag, ".done"}, 32'(if8.done),      32'(done));
    chk_eq({tag, ".pass"}, 32'(if8.pass),      32'(pass));
    chk_eq({tag, ".err8"}, 32'(if8.err_count), 32'(err8));
    chk_eq({tag, ".fv"},   32'(if8.fail_vec),  32'(fv));
    chk_eq({tag, ".err2"}, 32'(if2.err_count), 32'(err2));
    chk_eq({tag, ".done2"},32'(if2.done),      32'(done));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    loop    = 1'b0;
    y_mode  = 2'd0;

    // Reset values
    #2;
    chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    #10 rst_n = 1'b1;

    // Ideal NAND, full pass
    pulse_start();
    chk_status("ideal_e0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    adv(3);
    chk_status("ideal_e3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    adv(3);
    chk_status("ideal_e6", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    adv(5);
    chk_status("ideal_e11", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    adv(1);
    chk_status("ideal_e12", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 2'd0, 4'h0);
    adv(1);
    chk_status("ideal_e13", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 4'h0);

    // Abort while idle changes nothing
    abort = 1'b1;
    adv(2);
    abort = 1'b0;
    chk_status("idle_abort", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 2'd0, 4'h0);

    // Stuck-at-1: only vector 11 fails
    y_mode = 2'd1;
    pulse_start();
    chk_status("s1_e0", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    adv(12);
    chk_status("s1_e12", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1, 4'h8);

    // Stuck-at-0: vectors 00,01,10 fail
    y_mode = 2'd2;
    pulse_start();
    adv(12);
    chk_status("s0_e12", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 2'd3, 4'h7);

    // Start during RUN is ignored, abort at edge 5
    pulse_start();
    adv(1);
    start = 1'b1;
    adv(1);
    start = 1'b0;
    chk_status("ab_e2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    adv(2);
    chk_status("ab_e4", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1, 4'h1);
    abort = 1'b1;
    adv(1);
    abort = 1'b0;
    chk_status("ab_e5", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 4'h1);
    for (int i = 0; i < 10; i++) begin
      adv(1);
      chk_eq("ab_nodone", 32'(if8.done | if8.busy), 32'd0);
    end
    chk_status("ab_e15", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 2'd1, 4'h1);

    // Looping stuck-at-0: ERR_W=2 saturates at 3
    loop = 1'b1;
    pulse_start();
    adv(12);
    chk_status("lp_e12", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 2'd3, 4'h7);
    adv(1);
    chk_status("lp_e13", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 2'd3, 4'h7);
    adv(11);
    chk_status("lp_e24", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd6, 2'd3, 4'h7);
    loop = 1'b0;
    adv(12);
    chk_status("lp_e36", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd9, 2'd3, 4'h7);

    // Asynchronous reset mid-pass, then a clean ideal pass
    y_mode = 2'd0;
    pulse_start();
    adv(6);
    chk_status("rs_e6", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    adv(1);
    #2 rst_n = 1'b0;
    #1;
    chk_status("rs_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    #2 rst_n = 1'b1;
    adv(3);
    chk_status("rs_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 4'h0);
    pulse_start();
    adv(12);
    chk_status("rs_pass", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 2'd0, 4'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
